// File: rtl/n_bit_add_seq.sv
// Multi-cycle N-bit adder/subtractor. Processes W bits per clock, LSB chunk
// first, with one registered carry between chunks. Valid/ready on both sides.
module n_bit_add_seq #(
    parameter int unsigned N = 32,
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         sub,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int unsigned K  = N / W;
    localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e        state_q;
    logic [N-1:0]  op_a_q;
    logic [N-1:0]  op_b_q;
    logic [N-1:0]  sum_q;
    logic          carry_q;
    logic          cout_q;
    logic          ovf_q;
    logic [CW-1:0] cnt_q;

    logic [W:0]    chunk;
    logic [W-1:0]  res;
    logic          chunk_co;
    logic          msb_ci;
    logic [N-1:0]  sum_shift;
    logic [N-1:0]  op_a_shift;
    logic [N-1:0]  op_b_shift;

    // One W-bit slice of the ripple add; msb_ci recovers the carry into the
    // chunk's top bit, which on the last chunk is the carry into bit N-1.
    always_comb begin
        chunk    = {1'b0, op_a_q[W-1:0]} + {1'b0, op_b_q[W-1:0]} + {{W{1'b0}}, carry_q};
        res      = chunk[W-1:0];
        chunk_co = chunk[W];
        msb_ci   = res[W-1] ^ op_a_q[W-1] ^ op_b_q[W-1];
    end

    // With a single chunk the whole result comes from one add and nothing shifts.
    if (W == N) begin : g_single
        assign sum_shift  = res;
        assign op_a_shift = '0;
        assign op_b_shift = '0;
    end else begin : g_multi
        assign sum_shift  = {res, sum_q[N-1:W]};
        assign op_a_shift = {{W{1'b0}}, op_a_q[N-1:W]};
        assign op_b_shift = {{W{1'b0}}, op_b_q[N-1:W]};
    end

    // Control FSM and datapath registers; result outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        op_a_q  <= a;
                        // Subtract as A + ~B + ~borrow.
                        op_b_q  <= b ^ {N{sub}};
                        carry_q <= sub ? ~cin : cin;
                        cnt_q   <= '0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    op_a_q  <= op_a_shift;
                    op_b_q  <= op_b_shift;
                    sum_q   <= sum_shift;
                    carry_q <= chunk_co;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CW'(K - 1)) begin
                        cout_q  <= chunk_co;
                        ovf_q   <= msb_ci ^ chunk_co;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Handshake flags decode straight from the registered state.
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        sum       = sum_q;
        cout      = cout_q;
        ovf       = ovf_q;
    end

endmodule

// File: tb/tb_n_bit_add_seq.sv
// Self-checking bench for n_bit_add_seq: directed cases on N=32/W=8 and
// model-checked sweeps on N=16/W=16 and N=8/W=1.
module tb_n_bit_add_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // N=32, W=8 instance
    logic        iv32 = 0, ir32, ov32, or32 = 0, sub32 = 0, cin32 = 0, co32, ovf32;
    logic [31:0] a32 = 0, b32 = 0, s32;
    // N=16, W=16 instance
    logic        iv16 = 0, ir16, ov16, or16 = 0, sub16 = 0, cin16 = 0, co16, ovf16;
    logic [15:0] a16 = 0, b16 = 0, s16;
    // N=8, W=1 instance
    logic        iv8 = 0, ir8, ov8, or8 = 0, sub8 = 0, cin8 = 0, co8, ovf8;
    logic [7:0]  a8 = 0, b8 = 0, s8;

    n_bit_add_seq #(.N(32), .W(8)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
        .sub(sub32), .cin(cin32), .out_valid(ov32), .out_ready(or32), .sum(s32),
        .cout(co32), .ovf(ovf32)
    );
    n_bit_add_seq #(.N(16), .W(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
        .sub(sub16), .cin(cin16), .out_valid(ov16), .out_ready(or16), .sum(s16),
        .cout(co16), .ovf(ovf16)
    );
    n_bit_add_seq #(.N(8), .W(1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
        .sub(sub8), .cin(cin8), .out_valid(ov8), .out_ready(or8), .sum(s8),
        .cout(co8), .ovf(ovf8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one op on the 32-bit instance and wait for out_valid (bounded).
    // Called #1 after a rising edge with the block idle; returns #1 after an edge.
    task automatic op32(input logic [31:0] av, input logic [31:0] bv, input logic s,
                        input logic c, output int lat);
        a32 = av; b32 = bv; sub32 = s; cin32 = c; iv32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0;
        lat = 0;
        while (!ov32 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic consume32;
        or32 = 1'b1;
        @(posedge clk); #1;
        or32 = 1'b0;
    endtask

    task automatic dir32(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic s, input logic c, input logic [31:0] es,
                         input logic ec, input logic eo);
        int lat;
        op32(av, bv, s, c, lat);
        check({tag, "_lat"}, 64'(lat), 64'd4);
        check({tag, "_sum"}, 64'(s32), 64'(es));
        check({tag, "_cout"}, 64'(co32), 64'(ec));
        check({tag, "_ovf"}, 64'(ovf32), 64'(eo));
    endtask

    initial begin
        int lat;
        logic [31:0] held;

        #12;
        check("rst_in_ready", 64'(ir32), 64'd1);
        check("rst_out_valid", 64'(ov32), 64'd0);
        check("rst_sum", 64'(s32), 64'd0);
        check("rst_cout_ovf", 64'({co32, ovf32}), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        dir32("wrap", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
        consume32();
        check("idle_after_consume", 64'(ir32), 64'd1);
        dir32("pos_ovf", 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        consume32();
        dir32("neg_ovf", 32'h8000_0000, 32'h1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);
        consume32();
        dir32("sub_5_7", 32'd5, 32'd7, 1'b1, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
        consume32();
        dir32("sub_5_7_b", 32'd5, 32'd7, 1'b1, 1'b1, 32'hFFFF_FFFD, 1'b0, 1'b0);

        // Backpressure: stay in DONE with new operands offered.
        held = s32;
        a32 = 32'h1111_1111; b32 = 32'h2222_2222; sub32 = 1'b0; cin32 = 1'b0; iv32 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("bp_sum", 64'(s32), 64'(held));
            check("bp_flags", 64'({ov32, ir32, co32, ovf32}), 64'b1000);
        end
        or32 = 1'b1;
        @(posedge clk); #1;
        or32 = 1'b0; iv32 = 1'b0;
        check("bp_release_idle", 64'({ov32, ir32}), 64'b01);
        op32(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, lat);
        check("bp_next_lat", 64'(lat), 64'd4);
        check("bp_next_sum", 64'(s32), 64'h3333_3333);
        consume32();

        // Asynchronous reset during the second RUN cycle.
        a32 = 32'h1234_5678; b32 = 32'h1; sub32 = 1'b0; cin32 = 1'b0; iv32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0;
        @(posedge clk); #2;
        check("mid_run_sum_nonzero", 64'(s32 != 0), 64'd1);
        rst_n = 1'b0;
        #1;
        check("async_out_valid", 64'(ov32), 64'd0);
        check("async_sum", 64'(s32), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", 64'(ir32), 64'd1);
        op32(32'd3, 32'd4, 1'b0, 1'b0, lat);
        check("post_rst_lat", 64'(lat), 64'd4);
        check("post_rst_sum", 64'(s32), 64'd7);
        consume32();

        // Sweep N=16, W=16.
        for (int i = 0; i < 1000; i++) begin
            logic [15:0] bb;
            logic [16:0] full;
            logic        eo;
            a16 = 16'($urandom); b16 = 16'($urandom);
            sub16 = 1'($urandom); cin16 = 1'($urandom);
            bb = sub16 ? ~b16 : b16;
            full = {1'b0, a16} + {1'b0, bb} + 17'(sub16 ? !cin16 : cin16);
            eo = (a16[15] == bb[15]) && (full[15] != a16[15]);
            iv16 = 1'b1;
            @(posedge clk); #1;
            iv16 = 1'b0;
            lat = 0;
            while (!ov16 && lat < 40) begin
                @(posedge clk); #1;
                lat++;
            end
            check("w16_lat", 64'(lat), 64'd1);
            check("w16_sum", 64'(s16), 64'(full[15:0]));
            check("w16_cout", 64'(co16), 64'(full[16]));
            check("w16_ovf", 64'(ovf16), 64'(eo));
            or16 = 1'b1;
            @(posedge clk); #1;
            or16 = 1'b0;
        end

        // Sweep N=8, W=1.
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] bb;
            logic [8:0] full;
            logic       eo;
            a8 = 8'($urandom); b8 = 8'($urandom);
            sub8 = 1'($urandom); cin8 = 1'($urandom);
            bb = sub8 ? ~b8 : b8;
            full = {1'b0, a8} + {1'b0, bb} + 9'(sub8 ? !cin8 : cin8);
            eo = (a8[7] == bb[7]) && (full[7] != a8[7]);
            iv8 = 1'b1;
            @(posedge clk); #1;
            iv8 = 1'b0;
            lat = 0;
            while (!ov8 && lat < 40) begin
                @(posedge clk); #1;
                lat++;
            end
            check("w1_lat", 64'(lat), 64'd8);
            check("w1_sum", 64'(s8), 64'(full[7:0]));
            check("w1_cout", 64'(co8), 64'(full[8]));
            check("w1_ovf", 64'(ovf8), 64'(eo));
            or8 = 1'b1;
            @(posedge clk); #1;
            or8 = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/n_bit_add_seq.md
# n_bit_add_seq

Multi-cycle, parametrised N-bit adder/subtractor that processes operands W bits per clock, LSB chunk first, with a single registered carry between chunks. It replaces the fully combinational N-bit ripple adder where N is too wide to close timing in one cycle. It adds a subtract mode, carry-in, signed-overflow detection and valid/ready handshakes on input and output. It sits between operand-producing datapath stages and any consumer that tolerates an N/W-cycle latency.

## Interface
- N, 32, operand and result width in bits
- W, 8, chunk width processed per cycle; N % W == 0 required, 1 <= W <= N; K = N/W cycles per operation

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and mode are valid
- in_ready  output  1  block can accept an operation (high only in IDLE)
- a  input  N  operand A (two's complement when signed interpretation is used)
- b  input  N  operand B
- sub  input  1  0: A+B+cin; 1: A-B-cin
- cin  input  1  carry-in (add) / borrow-in (sub)
- out_valid  output  1  sum, cout and ovf are valid
- out_ready  input  1  consumer accepts the result
- sum  output  N  result, modulo 2^N
- cout  output  1  carry out of bit N-1 (for sub: 1 = no borrow)
- ovf  output  1  signed overflow

## Operation
- Single clock; reset is asynchronous and active-low.
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid, capture a into the operand register and b^{N{sub}} into the second operand register.
  - Initialise carry = sub ? ~cin : cin, clear the chunk counter, and go to RUN.
- RUN:
  - Each cycle, add the low W bits of both operand registers plus carry.
  - Shift the W-bit result into sum from the top: sum <= {res, sum[N-1:W]}.
  - Shift both operand registers right by W and register the chunk carry-out.
  - When the counter reaches K-1, also set cout = that chunk's carry-out and ovf = carry into bit N-1 XOR carry out of bit N-1, then go to DONE.
  - The counter is max(1, clog2(K)) bits wide.
- DONE:
  - out_valid=1; sum, cout and ovf are held stable.
  - When out_ready=1, go to IDLE.
- in_valid is ignored outside IDLE. No input is accepted in the same cycle a result is consumed.
- Arithmetic:
  - sub=0: {cout,sum} = A + B + cin.
  - sub=1: {cout,sum} = A + ~B + ~cin, i.e. A - B - cin.
- Only the sum and cout contents are meaningful while out_valid=1. Their values during RUN are intermediate.
- Reset (rst_n low at any time, including mid-RUN or in DONE):
  - State returns to IDLE; the operation in flight is discarded.
  - out_valid=0, sum=0, cout=0, ovf=0, counter=0.
  - in_ready=1 once state is IDLE.

## Timing
- in_ready = (state==IDLE); out_valid = (state==DONE). Both are decoded from the registered state, with no combinational path from in_valid or out_ready.
- Accept occurs at the rising edge where in_valid && in_ready.
- With acceptance at edge T, out_valid rises after edge T+K.
- Input accepted with W=N: K=1, so out_valid is high one cycle after acceptance.
- Minimum initiation interval: K+2 cycles (IDLE, K×RUN, DONE) with out_ready held high.
- Backpressure: out_valid stays high and all result outputs stay constant for as long as out_ready=0.

## Test plan
- N=32, W=8, a=0xFFFFFFFF, b=0x00000001, sub=0, cin=0 -> sum=0x00000000, cout=1, ovf=0. out_valid rises exactly 4 cycles after accept.
- N=32, W=8, a=0x7FFFFFFF, b=1, sub=0, cin=0 -> sum=0x80000000, cout=0, ovf=1. Separately, a=0x80000000, b=1, sub=1, cin=0 -> sum=0x7FFFFFFF, cout=1, ovf=1.
- N=32, W=8, a=5, b=7, sub=1, cin=0 -> sum=0xFFFFFFFE, cout=0, ovf=0. Same with cin=1 -> sum=0xFFFFFFFD.
- Backpressure: hold out_ready=0 for 6 cycles in DONE while driving in_valid=1 with new operands.
  - Required: sum, cout and ovf unchanged, in_ready=0, new operands not captured.
  - Raising out_ready returns the block to IDLE and the next operation is accepted.
- Reset: assert rst_n=0 in the 2nd RUN cycle.
  - Required: out_valid=0 and sum=0 immediately (asynchronous); in_ready=1 after release.
  - A new add of 3+4 afterwards gives sum=7.
- Parameter sweep (N=16, W=16) and (N=8, W=1): 1000 random operands, sub and cin per parameter set.
  - Compare against the model A±B±cin for sum, cout and ovf.
  - Check latency is 1 and 8 cycles respectively.
